// File: rtl/mem_burst_reader.sv
// mem_burst_reader
//   Burst read initiator for a memory with a 0-cycle combinational read port.
//   A command (base_addr, stride, length) is accepted in IDLE; one word per
//   cycle is then read and presented on a registered valid/ready stream with
//   full backpressure. done pulses for one cycle once the last word has been
//   handed to the consumer.
//
// Ports
//   clk, arst_n_in          clock (rising edge), async active-low reset
//   start                   command strobe, accepted only in IDLE
//   base_addr, stride       first address and per-word increment (wraps mod HEIGHT)
//   length                  words in the burst (0 allowed)
//   busy, done              burst in progress / one-cycle completion pulse
//   mem_read_addr/_en       memory read request
//   mem_qout                memory read data, valid in the same cycle as read_en
//   out_data/out_valid      output stream (registered)
//   out_ready               consumer backpressure
module mem_burst_reader #(
  parameter  int WIDTH  = 16,
  parameter  int HEIGHT = 1024,
  parameter  int LEN_W  = 16,
  localparam int ADDR_W = $clog2(HEIGHT)
) (
  input  logic              clk,
  input  logic              arst_n_in,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] stride,
  input  logic [LEN_W-1:0]  length,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_read_addr,
  output logic              mem_read_en,
  input  logic [WIDTH-1:0]  mem_qout,
  output logic [WIDTH-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_DRAIN
  } state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [ADDR_W-1:0]  stride_q, stride_d;
  logic [LEN_W-1:0]   remaining_q, remaining_d;
  logic [WIDTH-1:0]   out_data_q, out_data_d;
  logic               out_valid_q, out_valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               read_fire;

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      stride_q    <= '0;
      remaining_q <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      stride_q    <= stride_d;
      remaining_q <= remaining_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    stride_d    = stride_q;
    remaining_d = remaining_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    done_d      = 1'b0;

    // A read is issued only when the output register is free or being
    // emptied this cycle, so mem_qout is never sampled when it is not driven.
    read_fire = (state_q == S_READ) && (!out_valid_q || out_ready);

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
    if (read_fire) begin
      out_valid_d = 1'b1;
      out_data_d  = mem_qout;
    end

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d      = base_addr;
          stride_d    = stride;
          remaining_d = length;
          state_d     = (length != '0) ? S_READ : S_DRAIN;
        end
      end
      S_READ: begin
        if (read_fire) begin
          // ADDR_W truncation provides the mod-HEIGHT wrap.
          addr_d      = addr_q + stride_q;
          remaining_d = remaining_q - LEN_W'(1);
          if (remaining_q == LEN_W'(1)) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (!out_valid_q || out_ready) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  assign mem_read_en   = read_fire;
  assign mem_read_addr = addr_q;
  assign out_data      = out_data_q;
  assign out_valid     = out_valid_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

// File: tb/tb_mem_burst_reader.sv
// Testbench for mem_burst_reader: directed and random bursts checked against
// an address/data queue model built from (base + i*stride) mod HEIGHT.
module tb_mem_burst_reader;

  localparam int WIDTH  = 16;
  localparam int HEIGHT = 1024;
  localparam int LEN_W  = 16;
  localparam int ADDR_W = 10;

  logic              clk;
  logic              arst_n_in;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W-1:0] stride;
  logic [LEN_W-1:0]  length;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] mem_read_addr;
  logic              mem_read_en;
  logic [WIDTH-1:0]  mem_qout;
  logic [WIDTH-1:0]  out_data;
  logic              out_valid;
  logic              out_ready;

  logic [WIDTH-1:0]  mem [HEIGHT];

  mem_burst_reader #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .LEN_W(LEN_W)) dut (
    .clk          (clk),
    .arst_n_in    (arst_n_in),
    .start        (start),
    .base_addr    (base_addr),
    .stride       (stride),
    .length       (length),
    .busy         (busy),
    .done         (done),
    .mem_read_addr(mem_read_addr),
    .mem_read_en  (mem_read_en),
    .mem_qout     (mem_qout),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready)
  );

  assign mem_qout = mem_read_en ? mem[mem_read_addr] : 'x;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_asserts = 0;
  int n_fail    = 0;
  int cyc       = 0;

  int               exp_addr_q[$];
  logic [WIDTH-1:0] exp_data_q[$];

  bit burst_active;
  int start_cyc, first_read_cyc, first_valid_cyc, last_read_cyc, last_hs_cyc;
  int n_reads, n_hs, done_total, bursts_done;
  int stall_left;
  bit stall_used;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called mid-cycle (at negedge) with inputs settled for this cycle.
  task automatic observe();
    if (done) done_total++;
    if (burst_active) chk("busy_in_burst", {31'd0, busy}, 1);
    if (mem_read_en) begin
      n_reads++;
      if (first_read_cyc < 0) first_read_cyc = cyc;
      last_read_cyc = cyc;
      if (exp_addr_q.size() == 0) chk("read_expected", exp_addr_q.size(), 1);
      else chk("read_addr", {22'd0, mem_read_addr}, exp_addr_q.pop_front());
    end
    if (out_valid) begin
      if (first_valid_cyc < 0) first_valid_cyc = cyc;
      if (exp_data_q.size() == 0) chk("word_expected", exp_data_q.size(), 1);
      else begin
        chk("out_data", {16'd0, out_data}, {16'd0, exp_data_q[0]});
        if (out_ready) begin
          void'(exp_data_q.pop_front());
          n_hs++;
          last_hs_cyc = cyc;
        end
      end
      if (!out_ready) chk("no_read_in_stall", {31'd0, mem_read_en}, 0);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    observe();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  // mode 0: always ready; 1: three stall cycles while the second word is held;
  // 2: random ready.
  task automatic drive_ready(input int mode);
    case (mode)
      0: out_ready = 1'b1;
      1: begin
        if (!stall_used && n_hs == 1 && out_valid) begin
          stall_left = 3;
          stall_used = 1'b1;
        end
        out_ready = (stall_left == 0);
        if (stall_left > 0) stall_left--;
      end
      default: out_ready = ($urandom_range(0, 3) != 0);
    endcase
  endtask

  task automatic load_cmd(input int base, input int strd, input int len);
    for (int i = 0; i < len; i++) begin
      int a;
      a = (base + i * strd) % HEIGHT;
      exp_addr_q.push_back(a);
      exp_data_q.push_back(mem[a]);
    end
    n_reads = 0; n_hs = 0;
    first_read_cyc = -1; first_valid_cyc = -1;
    last_read_cyc = -1; last_hs_cyc = -1;
    stall_used = 1'b0; stall_left = 0;
    base_addr = ADDR_W'(base);
    stride    = ADDR_W'(strd);
    length    = LEN_W'(len);
  endtask

  // Starts a burst in the current cycle and returns in the cycle done is high.
  task automatic run_burst(input int base, input int strd, input int len,
                           input int mode, input bit collide);
    int guard;
    load_cmd(base, strd, len);
    start     = 1'b1;
    start_cyc = cyc;
    drive_ready(mode);
    tick();
    burst_active = 1'b1;
    guard = 0;
    while (!done && guard < 300) begin
      start = collide && (cyc <= start_cyc + 4);
      if (collide) length = LEN_W'(2);
      drive_ready(mode);
      tick();
      guard++;
    end
    start = 1'b0;
    burst_active = 1'b0;
    chk("done_seen", {31'd0, done}, 1);
    chk("busy_at_done", {31'd0, busy}, 0);
    chk("handshakes", n_hs, len);
    chk("reads", n_reads, len);
    chk("addr_q_empty", exp_addr_q.size(), 0);
    chk("data_q_empty", exp_data_q.size(), 0);
    if (len == 0) begin
      chk("zero_len_done_lat", cyc - start_cyc, 2);
      chk("zero_len_no_valid", first_valid_cyc, -1);
    end else begin
      chk("first_read_lat", first_read_cyc - start_cyc, 1);
      chk("first_valid_lat", first_valid_cyc - start_cyc, 2);
      chk("done_after_last_hs", cyc - last_hs_cyc, 1);
      if (mode == 0) chk("read_span", last_read_cyc - first_read_cyc, len - 1);
    end
    if (done) bursts_done++;
    exp_addr_q.delete();
    exp_data_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    int done_before;
    arst_n_in = 1'b0;
    start     = 1'b0;
    base_addr = '0;
    stride    = '0;
    length    = '0;
    out_ready = 1'b1;
    burst_active = 1'b0;
    done_total = 0;
    bursts_done = 0;
    for (int i = 0; i < HEIGHT; i++) mem[i] = WIDTH'($urandom);
    mem[10] = 16'hAAAA; mem[11] = 16'hBBBB; mem[12] = 16'hCCCC; mem[13] = 16'hDDDD;

    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_out_data", {16'd0, out_data}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_read_en", {31'd0, mem_read_en}, 0);
    chk("rst_read_addr", {22'd0, mem_read_addr}, 0);

    @(posedge clk); @(posedge clk); #1;
    arst_n_in = 1'b1;
    tick();

    // Basic burst
    run_burst(10, 1, 4, 0, 1'b0);
    tick();
    chk("done_single_pulse", {31'd0, done}, 0);

    // Backpressure while the second word is held
    run_burst(10, 1, 4, 1, 1'b0);
    chk("stall_applied", {31'd0, stall_used}, 1);
    tick();

    // Address wrap with non-unit stride
    run_burst(1020, 3, 3, 0, 1'b0);
    tick();

    // Zero-length burst
    run_burst(0, 1, 0, 0, 1'b0);
    tick();
    chk("zero_len_single_pulse", {31'd0, done}, 0);

    // start held mid-burst is ignored
    run_burst(100, 2, 6, 0, 1'b1);
    tick();
    chk("collide_idle_after", {31'd0, busy}, 0);

    // Back-to-back: second start lands in the done cycle of the first
    run_burst(200, 1, 3, 0, 1'b0);
    run_burst(300, 4, 3, 0, 1'b0);
    tick();

    // Reset after two of eight words
    load_cmd(400, 1, 8);
    start = 1'b1;
    start_cyc = cyc;
    out_ready = 1'b1;
    tick();
    start = 1'b0;
    burst_active = 1'b1;
    guard = 0;
    while (n_hs < 2 && guard < 50) begin
      tick();
      guard++;
    end
    chk("reset_setup_hs", n_hs, 2);
    burst_active = 1'b0;
    arst_n_in = 1'b0;
    #1;
    chk("mid_rst_out_valid", {31'd0, out_valid}, 0);
    chk("mid_rst_busy", {31'd0, busy}, 0);
    chk("mid_rst_read_en", {31'd0, mem_read_en}, 0);
    chk("mid_rst_out_data", {16'd0, out_data}, 0);
    exp_addr_q.delete();
    exp_data_q.delete();
    done_before = done_total;
    repeat (3) tick();
    arst_n_in = 1'b1;
    repeat (3) tick();
    chk("no_done_after_reset", done_total, done_before);

    // Fresh burst after reset
    run_burst(400, 1, 8, 0, 1'b0);
    tick();

    // Random bursts with random backpressure
    for (int k = 0; k < 6; k++) begin
      run_burst(int'($urandom_range(0, HEIGHT - 1)), int'($urandom_range(0, HEIGHT - 1)),
                int'($urandom_range(0, 12)), 2, 1'b0);
      out_ready = 1'b1;
      tick();
      chk("rand_done_single_pulse", {31'd0, done}, 0);
    end

    chk("done_pulse_total", done_total, bursts_done);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_burst_reader.md
Name: mem_burst_reader

Overview:
- Initiator on the read port of the on-chip/external memory model (0-cycle combinational read).
- Accepts a burst command (base, stride, length).
- Issues one read per cycle to the memory.
- Returns the words on a valid/ready output stream with full backpressure support.
- Sits between a memory instance and a compute consumer (e.g. PE-array input feeder), sustaining 1 word/cycle when out_ready stays high.

Parameters:
- WIDTH, 16, data word width (equals the memory WIDTH)
- HEIGHT, 1024, memory depth; ADDR_W = $clog2(HEIGHT)
- LEN_W, 16, width of the burst length field

Ports:
- clk  in  1  clock, rising edge
- arst_n_in  in  1  asynchronous active-low reset
- start  in  1  command strobe; accepted only in IDLE
- base_addr  in  ADDR_W  first read address
- stride  in  ADDR_W  address increment between words (unsigned)
- length  in  LEN_W  number of words in the burst (0 allowed)
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse at burst completion
- mem_read_addr  out  ADDR_W  to memory read_addr
- mem_read_en  out  1  to memory read_en
- mem_qout  in  WIDTH  from memory qout (valid in the same cycle as read_en)
- out_data  out  WIDTH  stream data (registered)
- out_valid  out  1  stream valid
- out_ready  in  1  stream ready from the consumer

Behaviour:
- Reset: the design reaches these values asynchronously on arst_n_in low, including mid-burst; the burst is abandoned and no done pulse is produced.
  - state=IDLE; busy=0, done=0, out_valid=0, out_data=0, mem_read_en=0, mem_read_addr=0; internal addr/remaining=0.
- FSM states: IDLE, READ, DRAIN.
- IDLE:
  - start=1 latches addr<=base_addr, stride, remaining<=length.
  - Next state is READ if length>0, else DRAIN.
  - start in READ/DRAIN is ignored; no queuing.
- READ:
  - mem_read_en = !out_valid || out_ready (comb). mem_read_addr = addr register.
  - On an edge with mem_read_en=1:
    - out_data<=mem_qout, out_valid<=1.
    - addr<=(addr+stride) mod HEIGHT: wrap by ADDR_W truncation; HEIGHT is required to be a power of 2.
    - remaining<=remaining-1.
    - When remaining==1, next state is DRAIN.
  - mem_qout is never sampled when mem_read_en=0 (the memory drives X).
- Output register:
  - out_valid is cleared on an edge where out_valid && out_ready && no new read occurs.
  - out_data is held stable while out_valid && !out_ready.
- DRAIN:
  - Waits until out_valid==0, or until the handshake out_valid && out_ready drains the last word.
  - Then done<=1 for exactly one cycle, busy<=0, state<=IDLE.
  - length=0: DRAIN is entered with out_valid=0, so done pulses 2 cycles after the start edge and no reads are issued.
- busy: 1 in READ and DRAIN, 0 in IDLE (registered with the state).
- Latency:
  - First read is in the cycle after start is accepted.
  - First out_valid is 2 cycles after the start cycle.
  - Throughput is 1 word/cycle with out_ready=1.
  - A new start is accepted in the same cycle done is high (state is IDLE).
- Out-of-burst activity: mem_read_en is 0 outside READ, so no memory energy is spent outside bursts.

Test Plan:
- Basic burst: base=10, stride=1, length=4, out_ready=1, mem[10..13]=A,B,C,D.
  - Required: reads addr 10,11,12,13 on consecutive cycles.
  - Required: out_data A,B,C,D on 4 consecutive valid cycles.
  - Required: done pulses once, the cycle after D is accepted.
- Backpressure: same burst, out_ready low for 3 cycles while holding B.
  - Required: mem_read_en=0 during the stall, out_data stays B.
  - Required: no word is lost or duplicated; total 4 handshakes.
- Wrap/stride: HEIGHT=1024, base=1020, stride=3, length=3.
  - Required: read addresses 1020, 1023, 2; the data matches.
- Zero length: start with length=0.
  - Required: no mem_read_en, out_valid stays 0, done pulse 2 cycles after start.
- Busy collision and back-to-back:
  - start mid-burst is ignored: exactly `length` words are produced.
  - start asserted in the done cycle is accepted; the next burst's first read is in the following cycle.
- Reset mid-burst: assert arst_n_in low after 2 of 8 words.
  - Required: out_valid, busy, mem_read_en drop to 0 immediately; no done pulse.
  - Required: a fresh burst works normally after release.
